uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. Captures each byte the receiver presents with its one-cycle `valid` strobe and stores it in a circular buffer. Presents bytes to the consumer (CPU bus bridge or command parser) over a first-word-fall-through ready/valid interface. Also reports fill level, a sticky overflow flag and a hardware flow-control output, so a slow consumer never silently loses bytes.

---
 rtl/uart_rx_fifo.sv | 79 +++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Output is first-word-fall-through. It also provides fill level, a sticky overflow flag and RTS flow control.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              rts_n
);

    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);

    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            rts_n_q, rts_n_d;
    logic            push, pop, drop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign overflow  = overflow_q;
    assign rts_n     = rts_n_q;

    // A pop in the same cycle frees the slot, so a push into a full buffer is allowed then
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
        // Registered from the current level, so rts_n trails count by one cycle
        rts_n_d = (count >= AFULL_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rts_n_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rts_n_q    <= rts_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// It includes a small queue model for the wrap-around section.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow;
    logic       rts_n;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_LEVEL(12)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .clr_overflow(clr_overflow), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; samples land 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ovalid"}, out_valid, 0);
        check({tag, "_odata"}, out_data, 8'h00);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_rts"}, rts_n, 0);
    endtask

    initial begin
        reset = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        #12;
        check_reset_vals("rst");
        #10 reset = 1'b1;
        step();

        // Single byte: visible the cycle after the write edge, then popped
        push(8'hA5);
        check("t1_ovalid", out_valid, 1);
        check("t1_odata", out_data, 8'hA5);
        check("t1_count", count, 1);
        check("t1_empty", empty, 0);
        pop();
        check("t1_count_pop", count, 0);
        check("t1_odata_pop", out_data, 8'h00);
        check("t1_ovalid_pop", out_valid, 0);

        // Fill to 16; rts_n follows count of the previous cycle
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("t2_count_fill", count, i + 1);
            check("t2_rts_fill", rts_n, (i >= 12) ? 1 : 0);
        end
        check("t2_full", full, 1);
        push(8'hFF);
        check("t2_ovf", overflow, 1);
        check("t2_count_drop", count, 16);
        for (int k = 0; k < 16; k++) begin
            check("t2_drain_data", out_data, 8'(k));
            pop();
            check("t2_count_drain", count, 15 - k);
            check("t2_rts_drain", rts_n, (k <= 4) ? 1 : 0);
        end
        check("t2_empty", empty, 1);
        check("t2_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // Full buffer: simultaneous push and pop keeps count at 16, no overflow
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t3_count", count, 16);
        check("t3_full", full, 1);
        check("t3_ovf", overflow, 0);
        for (int k = 1; k < 16; k++) begin
            check("t3_drain_data", out_data, 8'(8'h20 + k));
            pop();
        end
        check("t3_last", out_data, 8'h55);
        pop();
        check("t3_empty", empty, 1);

        // Wrap-around with random traffic at fill levels 0..3
        model_q.delete();
        for (int c = 0; c < 40; c++) begin
            logic do_push, do_pop;
            logic [7:0] d;
            do_push = 1'($urandom_range(0, 1));
            do_pop  = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (model_q.size() == 3 && !do_pop) do_push = 1'b0;
            if (do_pop && model_q.size() > 0) check("t4_data", out_data, model_q[0]);
            in_valid = do_push; in_data = d; out_ready = do_pop;
            step();
            in_valid = 1'b0; out_ready = 1'b0;
            if (do_pop && model_q.size() > 0) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
            check("t4_count", count, model_q.size());
            check("t4_ovalid", out_valid, (model_q.size() > 0) ? 1 : 0);
        end
        while (model_q.size() > 0) begin
            check("t4_tail", out_data, model_q[0]);
            void'(model_q.pop_front());
            pop();
        end
        check("t4_empty", empty, 1);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        in_valid = 1'b1; in_data = 8'h99; clr_overflow = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5_ovf_set_wins", overflow, 1);
        step();
        clr_overflow = 1'b0;
        check("t5_ovf_cleared", overflow, 0);
        push(8'h77);
        check("t5_ovf_reset_prep", overflow, 1);
        check("t5_rts_full", rts_n, 1);

        // Asynchronous reset from a full buffer with flags set
        #3 reset = 1'b0;
        #1 check_reset_vals("t6a");
        #2 reset = 1'b1;
        step();

        // Fill to 5, then reset between edges, then reuse
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        check("t6_count5", count, 5);
        #3 reset = 1'b0;
        #1 check_reset_vals("t6b");
        #2 reset = 1'b1;
        step();
        push(8'h3C);
        check("t6_odata", out_data, 8'h3C);
        check("t6_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
